// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the VC pop arbiter: FSM encodings, VC ids and
// default widths.
package vc_pop_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } arb_state_t;

    localparam logic VC0_ID = 1'b0;
    localparam logic VC1_ID = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 6;
    localparam int DEFAULT_DEST_BIT   = 4;

endpackage : vc_pop_arbiter_pkg

// File: rtl/vc_route_stage.sv
// Two-stage pop-to-push pipeline: remembers which VC was popped, then picks
// that VC's read data and steers it to D0 or D1 by the destination bit.
module vc_route_stage
    import vc_pop_arbiter_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int dest_bit   = DEFAULT_DEST_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  pop_VC0,
    input  logic                  pop_VC1,
    input  logic [data_width-1:0] data_out_VC0,
    input  logic [data_width-1:0] data_out_VC1,
    output logic                  vld1,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [data_width-1:0] data_out_D0,
    output logic [data_width-1:0] data_out_D1
);

    logic                  src1;
    logic [data_width-1:0] word;
    logic                  to_d1;

    // Source read data is valid the cycle after the pop, so select by src1.
    assign word  = (src1 == VC1_ID) ? data_out_VC1 : data_out_VC0;
    assign to_d1 = word[dest_bit];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld1        <= 1'b0;
            src1        <= VC0_ID;
            push_D0     <= 1'b0;
            push_D1     <= 1'b0;
            data_out_D0 <= '0;
            data_out_D1 <= '0;
        end else if (!init) begin
            vld1        <= 1'b0;
            src1        <= VC0_ID;
            push_D0     <= 1'b0;
            push_D1     <= 1'b0;
            data_out_D0 <= '0;
            data_out_D1 <= '0;
        end else begin
            vld1        <= pop_VC0 | pop_VC1;
            src1        <= pop_VC1 ? VC1_ID : VC0_ID;
            push_D0     <= vld1 & !to_d1;
            push_D1     <= vld1 & to_d1;
            data_out_D0 <= (vld1 && !to_d1) ? word : '0;
            data_out_D1 <= (vld1 && to_d1) ? word : '0;
        end
    end

endmodule : vc_route_stage

// File: rtl/vc_pop_arbiter.sv
// Strict-priority reader of the VC0/VC1 FIFOs feeding destination FIFOs D0/D1,
// with backpressure stall, status FSM and sticky error.
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int dest_bit   = DEFAULT_DEST_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  empty_fifo_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic [data_width-1:0] data_out_VC0,
    input  logic [data_width-1:0] data_out_VC1,
    input  logic                  error_VC0,
    input  logic                  error_VC1,
    input  logic                  full_fifo_D0,
    input  logic                  full_fifo_D1,
    input  logic                  almost_full_fifo_D0,
    input  logic                  almost_full_fifo_D1,
    output logic                  pop_VC0,
    output logic                  pop_VC1,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [data_width-1:0] data_out_D0,
    output logic [data_width-1:0] data_out_D1,
    output logic                  idle_out,
    output logic                  error_out,
    output logic [1:0]            arb_state
);

    arb_state_t state;
    logic       stall;
    logic       any_pending;
    logic       vld1;
    logic       push_fault;

    // The destination is unknown until the word is read, so any full or
    // almost-full destination blocks the pop.
    assign stall       = almost_full_fifo_D0 | almost_full_fifo_D1 | full_fifo_D0 | full_fifo_D1;
    assign any_pending = !empty_fifo_VC0 | !empty_fifo_VC1;

    assign pop_VC0 = reset & init & !stall & !empty_fifo_VC0;
    assign pop_VC1 = reset & init & !stall & empty_fifo_VC0 & !empty_fifo_VC1;

    assign push_fault = (push_D0 & full_fifo_D0) | (push_D1 & full_fifo_D1);

    vc_route_stage #(
        .data_width (data_width),
        .dest_bit   (dest_bit)
    ) u_route (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .pop_VC0      (pop_VC0),
        .pop_VC1      (pop_VC1),
        .data_out_VC0 (data_out_VC0),
        .data_out_VC1 (data_out_VC1),
        .vld1         (vld1),
        .push_D0      (push_D0),
        .push_D1      (push_D1),
        .data_out_D0  (data_out_D0),
        .data_out_D1  (data_out_D1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            error_out <= 1'b0;
        end else if (!init) begin
            state     <= ST_IDLE;
            error_out <= 1'b0;
        end else begin
            error_out <= error_out | error_VC0 | error_VC1 | push_fault;
            unique case (state)
                ST_IDLE: begin
                    if (any_pending) state <= stall ? ST_STALL : ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (stall)
                        state <= ST_STALL;
                    else if (!any_pending && !vld1 && !pop_VC0 && !pop_VC1)
                        state <= ST_IDLE;
                end
                ST_STALL: begin
                    if (!stall && any_pending)
                        state <= ST_ACTIVE;
                    else if (!stall && !vld1)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign arb_state = state;
    assign idle_out  = (state == ST_IDLE) & !vld1 & !push_D0 & !push_D1;

endmodule : vc_pop_arbiter

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter; source FIFOs are modelled as queues that
// deliver read data the cycle after a pop and clear on reset.
module tb_vc_pop_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b1;
    logic       empty_fifo_VC0 = 1'b1;
    logic       empty_fifo_VC1 = 1'b1;
    logic [5:0] data_out_VC0 = '0;
    logic [5:0] data_out_VC1 = '0;
    logic       error_VC0 = 1'b0;
    logic       error_VC1 = 1'b0;
    logic       full_fifo_D0 = 1'b0;
    logic       full_fifo_D1 = 1'b0;
    logic       almost_full_fifo_D0 = 1'b0;
    logic       almost_full_fifo_D1 = 1'b0;
    logic       pop_VC0, pop_VC1, push_D0, push_D1, idle_out, error_out;
    logic [5:0] data_out_D0, data_out_D1;
    logic [1:0] arb_state;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int checks = 0;
    int passed = 0;

    vc_pop_arbiter #(.data_width(6), .dest_bit(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .init                (init),
        .empty_fifo_VC0      (empty_fifo_VC0),
        .empty_fifo_VC1      (empty_fifo_VC1),
        .data_out_VC0        (data_out_VC0),
        .data_out_VC1        (data_out_VC1),
        .error_VC0           (error_VC0),
        .error_VC1           (error_VC1),
        .full_fifo_D0        (full_fifo_D0),
        .full_fifo_D1        (full_fifo_D1),
        .almost_full_fifo_D0 (almost_full_fifo_D0),
        .almost_full_fifo_D1 (almost_full_fifo_D1),
        .pop_VC0             (pop_VC0),
        .pop_VC1             (pop_VC1),
        .push_D0             (push_D0),
        .push_D1             (push_D1),
        .data_out_D0         (data_out_D0),
        .data_out_D1         (data_out_D1),
        .idle_out            (idle_out),
        .error_out           (error_out),
        .arb_state           (arb_state)
    );

    always #5 clk = ~clk;

    // Source FIFO model; words loaded by a task become visible after the next edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q0.delete();
            q1.delete();
            empty_fifo_VC0 <= 1'b1;
            empty_fifo_VC1 <= 1'b1;
            data_out_VC0   <= '0;
            data_out_VC1   <= '0;
        end else begin
            if (pop_VC0 && q0.size() > 0) data_out_VC0 <= q0.pop_front();
            if (pop_VC1 && q1.size() > 0) data_out_VC1 <= q1.pop_front();
            empty_fifo_VC0 <= (q0.size() == 0);
            empty_fifo_VC1 <= (q1.size() == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (idle_out && empty_fifo_VC0 && empty_fifo_VC1) break;
            step();
        end
        checks++; if (idle_out !== 1'b1) $display("FAIL drain_idle: got %b expected 1", idle_out); else passed++;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (push_D0 !== 1'b0 || push_D1 !== 1'b0) $display("FAIL rst_push: got %b%b expected 00", push_D0, push_D1); else passed++;
        checks++; if (data_out_D0 !== 6'h00 || data_out_D1 !== 6'h00) $display("FAIL rst_data: got %h/%h expected 00/00", data_out_D0, data_out_D1); else passed++;
        checks++; if (error_out !== 1'b0) $display("FAIL rst_error: got %b expected 0", error_out); else passed++;
        checks++; if (arb_state !== 2'b00) $display("FAIL rst_state: got %b expected 00", arb_state); else passed++;
        checks++; if (idle_out !== 1'b1) $display("FAIL rst_idle: got %b expected 1", idle_out); else passed++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        q0.push_back(6'h15);
        step();
        checks++; if (pop_VC0 !== 1'b1 || pop_VC1 !== 1'b0) $display("FAIL single_pop: got %b%b expected 10", pop_VC0, pop_VC1); else passed++;
        step();
        checks++; if (pop_VC0 !== 1'b0) $display("FAIL single_pop_once: got %b expected 0", pop_VC0); else passed++;
        checks++; if (arb_state !== 2'b01) $display("FAIL single_active: got %b expected 01", arb_state); else passed++;
        step();
        checks++; if (push_D1 !== 1'b1 || data_out_D1 !== 6'h15) $display("FAIL single_push_d1: got %b/%h expected 1/15", push_D1, data_out_D1); else passed++;
        checks++; if (push_D0 !== 1'b0 || data_out_D0 !== 6'h00) $display("FAIL single_d0_quiet: got %b/%h expected 0/00", push_D0, data_out_D0); else passed++;
        checks++; if (idle_out !== 1'b0) $display("FAIL single_busy: got %b expected 0", idle_out); else passed++;
        step();
        checks++; if (push_D1 !== 1'b0 || idle_out !== 1'b1) $display("FAIL single_done: got push=%b idle=%b expected push=0 idle=1", push_D1, idle_out); else passed++;
        checks++; if (arb_state !== 2'b00) $display("FAIL single_back_idle: got %b expected 00", arb_state); else passed++;
    endtask

    task automatic test_priority();
        q0.push_back(6'h03);
        q0.push_back(6'h12);
        q1.push_back(6'h0C);
        step();
        checks++; if (pop_VC0 !== 1'b1 || pop_VC1 !== 1'b0) $display("FAIL prio_first: got %b%b expected 10", pop_VC0, pop_VC1); else passed++;
        step();
        checks++; if (pop_VC0 !== 1'b1 || pop_VC1 !== 1'b0) $display("FAIL prio_second: got %b%b expected 10", pop_VC0, pop_VC1); else passed++;
        step();
        checks++; if (pop_VC0 !== 1'b0 || pop_VC1 !== 1'b1) $display("FAIL prio_vc1: got %b%b expected 01", pop_VC0, pop_VC1); else passed++;
        checks++; if (push_D0 !== 1'b1 || data_out_D0 !== 6'h03) $display("FAIL prio_push1: got %b/%h expected 1/03", push_D0, data_out_D0); else passed++;
        step();
        checks++; if (push_D1 !== 1'b1 || data_out_D1 !== 6'h12 || push_D0 !== 1'b0) $display("FAIL prio_push2: got d1=%b/%h d0=%b expected 1/12 0", push_D1, data_out_D1, push_D0); else passed++;
        step();
        checks++; if (push_D0 !== 1'b1 || data_out_D0 !== 6'h0C || push_D1 !== 1'b0) $display("FAIL prio_push3: got d0=%b/%h d1=%b expected 1/0c 0", push_D0, data_out_D0, push_D1); else passed++;
        drain();
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 1; i <= 5; i++) q0.push_back(6'(i));
        step();
        step();
        step();
        almost_full_fifo_D0 = 1'b1;
        #1;
        checks++; if (pop_VC0 !== 1'b0) $display("FAIL bp_pop_stop: got %b expected 0", pop_VC0); else passed++;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (push_D0 || push_D1) n++;
            if (i == 1) begin
                checks++; if (arb_state !== 2'b10) $display("FAIL bp_stall_state: got %b expected 10", arb_state); else passed++;
            end
            step();
        end
        checks++; if (n !== 2) $display("FAIL bp_inflight: got %0d pushes expected 2", n); else passed++;
        almost_full_fifo_D0 = 1'b0;
        #1;
        checks++; if (pop_VC0 !== 1'b1) $display("FAIL bp_resume_pop: got %b expected 1", pop_VC0); else passed++;
        step();
        checks++; if (arb_state !== 2'b01) $display("FAIL bp_resume_state: got %b expected 01", arb_state); else passed++;
        step();
        checks++; if (push_D0 !== 1'b1 || data_out_D0 !== 6'h03) $display("FAIL bp_resume_push: got %b/%h expected 1/03", push_D0, data_out_D0); else passed++;
        drain();
    endtask

    task automatic test_init();
        q0.push_back(6'h07);
        q0.push_back(6'h18);
        q0.push_back(6'h09);
        step();
        step();
        init = 1'b0;
        #1;
        checks++; if (pop_VC0 !== 1'b0) $display("FAIL init_no_pop: got %b expected 0", pop_VC0); else passed++;
        step();
        checks++; if (push_D0 !== 1'b0 || push_D1 !== 1'b0 || data_out_D0 !== 6'h00) $display("FAIL init_clear_push: got %b%b/%h expected 00/00", push_D0, push_D1, data_out_D0); else passed++;
        checks++; if (arb_state !== 2'b00 || idle_out !== 1'b1) $display("FAIL init_clear_state: got %b idle=%b expected 00 idle=1", arb_state, idle_out); else passed++;
        init = 1'b1;
        step();
        step();
        checks++; if (push_D1 !== 1'b1 || data_out_D1 !== 6'h18) $display("FAIL init_resume1: got %b/%h expected 1/18", push_D1, data_out_D1); else passed++;
        step();
        checks++; if (push_D0 !== 1'b1 || data_out_D0 !== 6'h09) $display("FAIL init_resume2: got %b/%h expected 1/09", push_D0, data_out_D0); else passed++;
        drain();
    endtask

    task automatic test_error();
        error_VC1 = 1'b1;
        #1;
        checks++; if (error_out !== 1'b0) $display("FAIL err_not_yet: got %b expected 0", error_out); else passed++;
        step();
        error_VC1 = 1'b0;
        checks++; if (error_out !== 1'b1) $display("FAIL err_set: got %b expected 1", error_out); else passed++;
        step();
        step();
        checks++; if (error_out !== 1'b1) $display("FAIL err_sticky: got %b expected 1", error_out); else passed++;
        init = 1'b0;
        step();
        init = 1'b1;
        checks++; if (error_out !== 1'b0) $display("FAIL err_init_clear: got %b expected 0", error_out); else passed++;
        q0.push_back(6'h05);
        step();
        step();
        full_fifo_D0 = 1'b1;
        step();
        checks++; if (push_D0 !== 1'b1 || data_out_D0 !== 6'h05) $display("FAIL err_push_goes: got %b/%h expected 1/05", push_D0, data_out_D0); else passed++;
        checks++; if (error_out !== 1'b0) $display("FAIL err_full_early: got %b expected 0", error_out); else passed++;
        step();
        full_fifo_D0 = 1'b0;
        checks++; if (error_out !== 1'b1) $display("FAIL err_full_set: got %b expected 1", error_out); else passed++;
        drain();
    endtask

    task automatic test_reset_midstream();
        int n;
        q0.push_back(6'h11);
        q0.push_back(6'h22);
        q0.push_back(6'h33);
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (push_D0 !== 1'b0 || push_D1 !== 1'b0 || pop_VC0 !== 1'b0) $display("FAIL midrst_quiet: got push=%b%b pop=%b expected 00 0", push_D0, push_D1, pop_VC0); else passed++;
        checks++; if (error_out !== 1'b0 || arb_state !== 2'b00 || idle_out !== 1'b1) $display("FAIL midrst_status: got err=%b st=%b idle=%b expected 0 00 1", error_out, arb_state, idle_out); else passed++;
        step();
        step();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (push_D0 || push_D1) n++;
        end
        checks++; if (n !== 0) $display("FAIL midrst_no_push: got %0d pushes expected 0", n); else passed++;
        checks++; if (idle_out !== 1'b1) $display("FAIL midrst_idle: got %b expected 1", idle_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_priority();
        test_backpressure();
        test_init();
        test_error();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_vc_pop_arbiter
